// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter
// Description : 4-requester round-robin arbiter driving a registered-select
//               4:1 data mux with valid/ready handshake. Optional grant lock
//               is enabled by defining MUX4_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst,
`ifdef MUX4_ARB_LOCK_EN
  input  logic [3:0]          lock,
`endif
  input  logic [3:0]          req,
  input  logic [4*DATA_W-1:0] data_in,
  input  logic                out_ready,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  output logic [1:0]          sel,
  output logic [3:0]          gnt,
  output logic [3:0]          ack
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [1:0] r_sel, w_sel_nxt;
  logic [3:0] r_gnt, w_gnt_nxt;
  logic [1:0] w_ptr_inc;
  logic       w_busy;
  logic       w_xfer;
  logic       w_lock_hold;
  logic [2:0] w_pick_idle;
  logic [2:0] w_pick_xfer;

  // Returns {found, index}; the candidate closest to base (in wrap order) wins.
  function automatic logic [2:0] f_pick(input logic [3:0] cand, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (cand[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  assign w_busy      = (r_state == S_BUSY);
  assign w_xfer      = w_busy & out_ready;
  assign w_ptr_inc   = r_sel + 2'd1;
  assign w_pick_idle = f_pick(req, r_ptr);
  // The served requester is masked so it cannot win the cycle it is acked.
  assign w_pick_xfer = f_pick(req & ~r_gnt, w_ptr_inc);

`ifdef MUX4_ARB_LOCK_EN
  // A lock only holds a winner that is still requesting.
  assign w_lock_hold = lock[r_sel] & req[r_sel];
`else
  assign w_lock_hold = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_gnt_nxt   = r_gnt;
    case (r_state)
      S_IDLE: begin
        if (w_pick_idle[2]) begin
          w_state_nxt = S_BUSY;
          w_sel_nxt   = w_pick_idle[1:0];
          w_gnt_nxt   = 4'b0001 << w_pick_idle[1:0];
        end
      end
      S_BUSY: begin
        if (out_ready) begin
          if (!w_lock_hold) begin
            w_ptr_nxt = w_ptr_inc;
            if (w_pick_xfer[2]) begin
              w_sel_nxt = w_pick_xfer[1:0];
              w_gnt_nxt = 4'b0001 << w_pick_xfer[1:0];
            end else begin
              w_state_nxt = S_IDLE;
              w_gnt_nxt   = 4'b0000;
            end
          end
        end else if (!req[r_sel]) begin
          w_state_nxt = S_IDLE;
          w_gnt_nxt   = 4'b0000;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_sel   <= 2'd0;
      r_gnt   <= 4'b0000;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
      r_gnt   <= w_gnt_nxt;
    end
  end

  assign out_valid = w_busy;
  assign out_data  = w_busy ? data_in[r_sel*DATA_W +: DATA_W] : '0;
  assign sel       = r_sel;
  assign gnt       = r_gnt;
  assign ack       = w_xfer ? r_gnt : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// Testbench for mux4_rr_arbiter: directed scenarios plus randomized traffic
// checked against a queue-free arithmetic round-robin model.
module tb_mux4_rr_arbiter;

  localparam int DATA_W = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [3:0]          req = 4'b0000;
  logic [4*DATA_W-1:0] data_in = '0;
  logic                out_ready = 1'b0;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic [1:0]          sel;
  logic [3:0]          gnt;
  logic [3:0]          ack;
`ifdef MUX4_ARB_LOCK_EN
  logic [3:0]          lock = 4'b0000;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: busy flag, pointer, current winner and last select value.
  bit m_busy;
  int m_ptr, m_win, m_sel;

  mux4_rr_arbiter #(.DATA_W(DATA_W)) dut (
    .clk(clk),
    .rst(rst),
`ifdef MUX4_ARB_LOCK_EN
    .lock(lock),
`endif
    .req(req),
    .data_in(data_in),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data(out_data),
    .sel(sel),
    .gnt(gnt),
    .ack(ack)
  );

  always #5 clk = ~clk;

  function automatic int m_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [DATA_W-1:0] slice(input int i);
    return data_in[i*DATA_W +: DATA_W];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ptr = 0; m_win = 0; m_sel = 0;
  endtask

  task automatic model_step();
    int w;
    bit locked;
    locked = 0;
`ifdef MUX4_ARB_LOCK_EN
    locked = lock[m_win] && req[m_win];
`endif
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      w = m_pick(req, m_ptr);
      if (w >= 0) begin m_busy = 1; m_win = w; m_sel = w; end
    end else if (out_ready) begin
      if (!locked) begin
        m_ptr = (m_win + 1) % 4;
        w = m_pick(req & ~(4'b0001 << m_win), m_ptr);
        if (w >= 0) begin m_win = w; m_sel = w; end
        else m_busy = 0;
      end
    end else if (!req[m_win]) begin
      m_busy = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic pulse_rst();
    #2 rst = 1'b1;
    model_reset();
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    req = 4'b1111; out_ready = 1'b1; data_in = 32'hDEADBEEF;
    model_reset();
    #2;
    n_checks++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b expected 0000", gnt); else n_pass++;
    n_checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) $display("FAIL reset_out: got %b/%h expected 0/00", out_valid, out_data); else n_pass++;
    cyc();
    n_checks++; if (sel !== 2'd0 || ack !== 4'b0000 || gnt !== 4'b0000) $display("FAIL reset_held: got sel %0d ack %b gnt %b expected 0 0000 0000", sel, ack, gnt); else n_pass++;
    rst = 1'b0; req = 4'b0000;
    cyc();
  endtask

  task automatic test_alternate();
    logic [3:0] exp_g [4];
    int         exp_p [4];
    exp_g = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    exp_p = '{1, 3, 1, 3};
    req = 4'b0101; out_ready = 1'b1;
    #2;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL alt_latency: got valid %b expected 0", out_valid); else n_pass++;
    cyc();
    for (int i = 0; i < 4; i++) begin
      #2;
      n_checks++; if (gnt !== exp_g[i] || ack !== exp_g[i]) $display("FAIL alt_gnt[%0d]: got gnt %b ack %b expected %b", i, gnt, ack, exp_g[i]); else n_pass++;
      cyc();
      n_checks++; if (int'(dut.r_ptr) !== exp_p[i]) $display("FAIL alt_ptr[%0d]: got %0d expected %0d", i, dut.r_ptr, exp_p[i]); else n_pass++;
    end
    req = 4'b0000; out_ready = 1'b0;
    cyc();
  endtask

  task automatic test_round_robin();
    pulse_rst();
    req = 4'b1111; out_ready = 1'b1; data_in = 32'h44332211;
    cyc();
    for (int i = 0; i < 5; i++) begin
      #2;
      n_checks++;
      if (sel !== 2'(i % 4) || ack !== (4'b0001 << (i % 4)) || out_valid !== 1'b1 || out_data !== 8'(8'h11 * ((i % 4) + 1)))
        $display("FAIL rr_step[%0d]: got sel %0d ack %b valid %b data %h expected sel %0d", i, sel, ack, out_valid, out_data, i % 4);
      else n_pass++;
      cyc();
    end
    req = 4'b0000; out_ready = 1'b0;
    cyc();
  endtask

  task automatic test_backpressure();
    pulse_rst();
    req = 4'b1000; out_ready = 1'b0; data_in = 32'hA5_3C_7E_01;
    cyc();
    for (int i = 0; i < 5; i++) begin
      #2;
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== 8'hA5 || ack !== 4'b0000 || gnt !== 4'b1000)
        $display("FAIL bp_hold[%0d]: got valid %b data %h ack %b gnt %b expected 1 a5 0000 1000", i, out_valid, out_data, ack, gnt);
      else n_pass++;
      cyc();
    end
    out_ready = 1'b1;
    #2;
    n_checks++; if (ack !== 4'b1000) $display("FAIL bp_ack: got %b expected 1000", ack); else n_pass++;
    cyc();
    req = 4'b0000;
    #2;
    n_checks++; if (out_valid !== 1'b0 || gnt !== 4'b0000) $display("FAIL bp_idle: got valid %b gnt %b expected 0 0000", out_valid, gnt); else n_pass++;
    out_ready = 1'b0;
    cyc();
  endtask

  task automatic test_withdraw_reset();
    pulse_rst();
    req = 4'b0100; out_ready = 1'b0;
    cyc();
    n_checks++; if (sel !== 2'd2 || gnt !== 4'b0100) $display("FAIL wd_grant: got sel %0d gnt %b expected 2 0100", sel, gnt); else n_pass++;
    req = 4'b0000;
    cyc();
    #2;
    n_checks++; if (gnt !== 4'b0000 || out_valid !== 1'b0 || dut.r_ptr !== 2'd0) $display("FAIL wd_release: got gnt %b valid %b ptr %0d expected 0000 0 0", gnt, out_valid, dut.r_ptr); else n_pass++;
    req = 4'b1000;
    cyc();
    #1 rst = 1'b1;
    model_reset();
    #1;
    n_checks++; if (gnt !== 4'b0000 || out_valid !== 1'b0 || out_data !== 8'h00 || ack !== 4'b0000 || sel !== 2'd0)
      $display("FAIL rst_abort: got gnt %b valid %b data %h ack %b sel %0d expected all zero", gnt, out_valid, out_data, ack, sel);
    else n_pass++;
    req = 4'b1001;
    cyc();
    rst = 1'b0;
    cyc();
    #2;
    n_checks++; if (gnt !== 4'b0001) $display("FAIL rst_restart: got gnt %b expected 0001", gnt); else n_pass++;
    req = 4'b0000;
    cyc();
  endtask

`ifdef MUX4_ARB_LOCK_EN
  task automatic test_lock();
    pulse_rst();
    req = 4'b0011; lock = 4'b0001; out_ready = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) begin
      #2;
      n_checks++; if (sel !== 2'd0 || ack !== 4'b0001) $display("FAIL lock_hold[%0d]: got sel %0d ack %b expected 0 0001", i, sel, ack); else n_pass++;
      cyc();
    end
    lock = 4'b0000;
    cyc();
    #2;
    n_checks++; if (sel !== 2'd1) $display("FAIL lock_release: got sel %0d expected 1", sel); else n_pass++;
    req = 4'b0000; out_ready = 1'b0;
    cyc();
  endtask
`endif

  task automatic test_random();
    logic [3:0] eg;
    for (int n = 0; n < 400; n++) begin
      req       = 4'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      data_in   = $urandom;
`ifdef MUX4_ARB_LOCK_EN
      lock      = 4'($urandom) & 4'($urandom);
`endif
      if ($urandom_range(0, 63) == 0) begin
        rst = 1'b1;
        model_reset();
      end
      #2;
      eg = m_busy ? (4'b0001 << m_win) : 4'b0000;
      n_checks++; if (out_valid !== m_busy) $display("FAIL rnd_valid[%0d]: got %b expected %b", n, out_valid, m_busy); else n_pass++;
      n_checks++; if (gnt !== eg) $display("FAIL rnd_gnt[%0d]: got %b expected %b", n, gnt, eg); else n_pass++;
      n_checks++; if (int'(sel) !== m_sel) $display("FAIL rnd_sel[%0d]: got %0d expected %0d", n, sel, m_sel); else n_pass++;
      n_checks++; if (out_data !== (m_busy ? slice(m_win) : 8'h00)) $display("FAIL rnd_data[%0d]: got %h expected %h", n, out_data, m_busy ? slice(m_win) : 8'h00); else n_pass++;
      n_checks++; if (ack !== (out_ready ? eg : 4'b0000)) $display("FAIL rnd_ack[%0d]: got %b expected %b", n, ack, out_ready ? eg : 4'b0000); else n_pass++;
      n_checks++; if ($countones(gnt) > 1) $display("FAIL rnd_onehot[%0d]: got %b expected at most one bit", n, gnt); else n_pass++;
      cyc();
      rst = 1'b0;
    end
    req = 4'b0000; out_ready = 1'b0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_alternate();
    test_round_robin();
    test_backpressure();
    test_withdraw_reset();
`ifdef MUX4_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter: DATA_W, 8, width of each requester data word and of out_data.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: req  input  4  per-requester request; req[i] high means data_in slice i holds a valid word.
REQ-005 Port: data_in  input  4*DATA_W  requester words; slice i = data_in[i*DATA_W +: DATA_W].
REQ-006 Port: out_ready  input  1  consumer ready.
REQ-007 Port: out_valid  output  1  selected word valid.
REQ-008 Port: out_data  output  DATA_W  selected word.
REQ-009 Port: sel  output  2  registered select of the 4:1 datapath mux; equals index of current winner.
REQ-010 Port: gnt  output  4  registered one-hot grant; all-zero when idle.
REQ-011 Port: ack  output  4  per-requester transfer strobe; ack[i] = gnt[i] & out_ready while BUSY.

Function
REQ-012 The block SHALL have two states, IDLE and BUSY, plus a 2-bit round-robin pointer ptr.
REQ-013 Arbitration SHALL pick the first set candidate bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-014 In IDLE with req != 0, the next edge SHALL enter BUSY with gnt/sel set to the winner over req; latency request-to-out_valid is one cycle.
REQ-015 In IDLE with req == 0, state, gnt, sel and ptr SHALL hold.
REQ-016 In BUSY, out_valid SHALL be 1 and out_data SHALL equal data_in slice sel combinationally; in IDLE, out_valid = 0 and out_data = 0.
REQ-017 A transfer SHALL occur in any BUSY cycle with out_ready = 1; exactly one ack bit pulses that cycle.
REQ-018 On transfer, ptr SHALL become sel+1 (mod 4, 2-bit wrap 3->0).
REQ-019 On transfer, the block SHALL re-arbitrate over req & ~gnt using the updated ptr; a winner stays BUSY back-to-back, none goes to IDLE.
REQ-020 The just-served requester SHALL NOT be regranted in the transfer cycle even if its req stays high; earliest regrant is the following arbitration.
REQ-021 In BUSY with out_ready = 0, gnt, sel and ptr SHALL hold regardless of other req changes.
REQ-022 If req[sel] falls in BUSY without a transfer (withdrawal), the next edge SHALL return to IDLE with gnt = 0 and ptr unchanged.
REQ-023 Withdrawal and out_ready = 1 in the same cycle SHALL count as a transfer (REQ-018/019 apply).
REQ-024 gnt SHALL never have more than one bit set.

Reset
REQ-025 While rst = 1: state IDLE, ptr = 0, gnt = 0, sel = 0, out_valid = 0, out_data = 0, ack = 0, independent of clk.
REQ-026 Reset asserted mid-BUSY SHALL abort the grant without ack; after release, arbitration restarts from ptr = 0.

Configuration
REQ-027 Macro MUX4_ARB_LOCK_EN SHALL, when defined, add input lock (4 bits); at a transfer with lock[sel] = 1 the block SHALL stay BUSY on the same winner and leave ptr unchanged.
REQ-028 With MUX4_ARB_LOCK_EN defined, lock SHALL be ignored outside transfer cycles and withdrawal (REQ-022) SHALL still release the grant.
REQ-029 Without MUX4_ARB_LOCK_EN, port lock SHALL not exist and every transfer SHALL follow REQ-018/019.

Verification
REQ-030 Reset, req=4'b0101, out_ready=1 held -> gnt sequence 0001,0100,0001,0100; ptr 1,3,1,3 after each ack.
REQ-031 req=4'b1111, out_ready=1 -> sel 0,1,2,3,0 with ack one-hot each cycle, no idle bubble.
REQ-032 req=4'b1000 granted, out_ready=0 for 5 cycles, data_in slice 3=8'hA5 -> out_valid=1, out_data=8'hA5 held, no ack; then out_ready=1 -> ack=4'b1000, next cycle IDLE.
REQ-033 BUSY on sel=2, req[2] dropped with out_ready=0 -> next cycle gnt=0, out_valid=0, ptr unchanged; rst pulsed mid-BUSY -> all outputs 0 immediately, first grant after release goes to requester 0 if req[0]=1.
REQ-034 MUX4_ARB_LOCK_EN defined, req=4'b0011, lock=4'b0001, out_ready=1 -> sel stays 0 for 3 acks; lock cleared -> next transfer moves to sel=1.
